dmem_lsu: RTL and testbench

- Parametrised load/store data memory that succeeds the single-width, always-ready data memory in the RV64I datapath.
- Adds a valid/ready request handshake and a configurable access latency.
- Supports RISC-V sized accesses (byte, half, word, double) with sign or zero extension on loads and byte-lane writes on stores.
- Flags misaligned, out-of-range and illegal-size accesses with an error response.
- Sits between the ALU address/rs2 outputs and the MemtoReg write-back mux; a multi-cycle control FSM stalls the pipeline on req_ready.

---
 rtl/dmem_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu
//   Load/store data memory for the RV64I datapath with a valid/ready request
//   handshake and a configurable access latency. Supports byte/half/word/
//   double accesses with sign or zero extension on loads and byte-lane writes
//   on stores. Misaligned, out-of-range and illegal-size accesses return an
//   error response and never touch memory.
//
// Parameters
//   XLEN    : data and address width (32 or 64)
//   DEPTH   : number of XLEN-wide memory words (power of 2)
//   LATENCY : cycles from request acceptance to memory commit (>= 1)
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RISC-V size/sign code
//   req_addr, req_wdata : byte address and store data (low bytes used)
//   resp_valid          : one-cycle response strobe
//   resp_rdata          : extended load data (0 for stores and errors)
//   resp_err            : access rejected (qualify with resp_valid)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_lsu #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int W       = XLEN / 8;
  localparam int OFFW    = $clog2(W);
  localparam int IDXBITS = $clog2(DEPTH);
  localparam int IDXW    = (DEPTH > 1) ? IDXBITS : 1;
  localparam int CNTW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [XLEN-1:0]   mem [DEPTH];

  logic [OFFW-1:0]   offset;
  logic [IDXW-1:0]   word_idx;
  logic              out_of_range;
  logic              misaligned;
  logic              illegal_size;
  logic              err_access;
  logic [XLEN-1:0]   mem_word;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;
  logic [W-1:0]      size_mask;
  logic [W-1:0]      byte_en;
  logic [XLEN-1:0]   lane_data;
  logic              commit;
  logic              mem_we;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Access decode on the latched request. The range check looks at every
  // address bit above the word index so high addresses never alias low words.
  always_comb begin
    offset       = addr_q[OFFW-1:0];
    word_idx     = addr_q[OFFW +: IDXW];
    out_of_range = (addr_q >> (OFFW + IDXBITS)) != '0;

    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      default: misaligned = |addr_q[2:0];
    endcase

    illegal_size = (funct3_q == 3'b111)
                || ((XLEN == 32) && ((funct3_q == 3'b011) || (funct3_q == 3'b110)))
                || (we_q && funct3_q[2]);

    err_access = illegal_size | misaligned | out_of_range;
  end

  // Load path: shift the addressed word so the access starts at byte 0, then
  // extend. Size casts of a signed operand sign-extend, of unsigned zero-extend.
  always_comb begin
    mem_word = mem[word_idx];
    shifted  = mem_word >> {offset, 3'b000};
    load_ext = '0;
    case (funct3_q[1:0])
      2'b00:   load_ext = funct3_q[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   load_ext = funct3_q[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   load_ext = funct3_q[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: load_ext = shifted;
    endcase
  end

  // Store path: lane enables and store data moved up to the byte offset.
  always_comb begin
    size_mask = '0;
    case (funct3_q[1:0])
      2'b00:   size_mask = W'(1);
      2'b01:   size_mask = W'(3);
      2'b10:   size_mask = W'(15);
      default: size_mask = '1;
    endcase
    byte_en   = size_mask << offset;
    lane_data = wdata_q << {offset, 3'b000};
    commit    = (state_q == BUSY) && (cnt_q == '0);
    mem_we    = commit && we_q && !err_access;
  end

  // Next-state logic for the IDLE -> BUSY -> RESP handshake FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CNTW'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_access;
          resp_rdata_d = (we_q || err_access) ? '0 : load_ext;
          state_d      = RESP;
        end
      end
      RESP: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory array is not reset. A reset during BUSY forces state_q to IDLE
  // asynchronously, which drops mem_we and so aborts a pending store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < W; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
`timescale 1ns/1ps
module tb_dmem_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_m;
  logic        reset_b;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        valid_a, valid_b, valid_c;
  logic        ready_a, ready_b, ready_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        err_a, err_b, err_c;
  logic [63:0] rdata_a, rdata_b;
  logic [31:0] rdata_c;

  // sel 0: XLEN=64 LATENCY=1 ; sel 1: XLEN=64 LATENCY=4 ; sel 2: XLEN=32 LATENCY=3
  dmem_lsu #(.XLEN(64), .DEPTH(1024), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset_m), .req_valid(valid_a), .req_ready(ready_a),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rvalid_a), .resp_rdata(rdata_a),
    .resp_err(err_a));

  dmem_lsu #(.XLEN(64), .DEPTH(1024), .LATENCY(4)) dut_b (
    .clk(clk), .reset(reset_b), .req_valid(valid_b), .req_ready(ready_b),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rvalid_b), .resp_rdata(rdata_b),
    .resp_err(err_b));

  dmem_lsu #(.XLEN(32), .DEPTH(1024), .LATENCY(3)) dut_c (
    .clk(clk), .reset(reset_m), .req_valid(valid_c), .req_ready(ready_c),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[31:0]), .resp_valid(rvalid_c), .resp_rdata(rdata_c),
    .resp_err(err_c));

  typedef struct {
    int          sel;
    bit          we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void add(int sel, bit we, logic [2:0] f3, logic [63:0] addr,
                              logic [63:0] wdata, logic [63:0] exp_rdata,
                              bit exp_err, int exp_lat, string name);
    vec_t v;
    v.sel = sel; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic logic get_ready(int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic get_rvalid(int sel);
    case (sel)
      0:       return rvalid_a;
      1:       return rvalid_b;
      default: return rvalid_c;
    endcase
  endfunction

  function automatic logic get_err(int sel);
    case (sel)
      0:       return err_a;
      1:       return err_b;
      default: return err_c;
    endcase
  endfunction

  function automatic logic [63:0] get_rdata(int sel);
    case (sel)
      0:       return rdata_a;
      1:       return rdata_b;
      default: return {32'h0, rdata_c};
    endcase
  endfunction

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       valid_a = v;
      1:       valid_b = v;
      default: valid_c = v;
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Issue one request, wait for acceptance, then sample #1 after each edge:
  // lat = edges from acceptance to resp_valid, busy = samples with req_ready low.
  task automatic applyStimulus(input int sel, input bit we, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               output logic [63:0] rdata, output logic err,
                               output int lat, output int busy);
    int guard;
    rdata = '0; err = 1'b0; lat = -1; busy = 0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    set_valid(sel, 1'b1);
    guard = 0;
    while (!get_ready(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      set_valid(sel, 1'b0);
      n_cmp++; n_fail++;
      $display("[TB] FAIL accept_timeout: sel %0d never raised req_ready, required 1", sel);
      return;
    end
    @(posedge clk);
    #1 set_valid(sel, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (get_rvalid(sel)) begin
        lat   = k;
        rdata = get_rdata(sel);
        err   = get_err(sel);
      end
      if (get_ready(sel)) break;
      busy++;
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat, busy;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_m = 1'b1; reset_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    #1;
    checkOutput("rst_ready_a",  64'(ready_a),  64'd1);
    checkOutput("rst_rvalid_a", 64'(rvalid_a), 64'd0);
    checkOutput("rst_rdata_a",  rdata_a,       64'd0);
    checkOutput("rst_err_a",    64'(err_a),    64'd0);
    checkOutput("rst_ready_b",  64'(ready_b),  64'd1);
    checkOutput("rst_ready_c",  64'(ready_c),  64'd1);
    repeat (3) @(negedge clk);
    reset_m = 1'b0; reset_b = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_ready_a",  64'(ready_a),  64'd1);
    checkOutput("idle_rvalid_a", 64'(rvalid_a), 64'd0);

    // XLEN=64, LATENCY=1
    add(0, 1, 3'b011, 64'h0,    64'h0123456789ABCDEF, 64'h0,                0, 1, "sd_0");
    add(0, 1, 3'b011, 64'h20,   64'h8877665544332211, 64'h0,                0, 1, "sd_20");
    add(0, 0, 3'b011, 64'h20,   64'h0,                64'h8877665544332211, 0, 1, "ld_20");
    add(0, 0, 3'b000, 64'h27,   64'h0,                64'hFFFFFFFFFFFFFF88, 0, 1, "lb_27");
    add(0, 0, 3'b100, 64'h27,   64'h0,                64'h0000000000000088, 0, 1, "lbu_27");
    add(0, 0, 3'b001, 64'h26,   64'h0,                64'hFFFFFFFFFFFF8877, 0, 1, "lh_26");
    add(0, 0, 3'b101, 64'h26,   64'h0,                64'h0000000000008877, 0, 1, "lhu_26");
    add(0, 0, 3'b010, 64'h24,   64'h0,                64'hFFFFFFFF88776655, 0, 1, "lw_24");
    add(0, 0, 3'b110, 64'h24,   64'h0,                64'h0000000088776655, 0, 1, "lwu_24");
    add(0, 1, 3'b000, 64'h21,   64'h123456789ABCDEAB, 64'h0,                0, 1, "sb_21");
    add(0, 0, 3'b011, 64'h20,   64'h0,                64'h887766554433AB11, 0, 1, "ld_after_sb");
    add(0, 1, 3'b001, 64'h22,   64'h555500001111BEEF, 64'h0,                0, 1, "sh_22");
    add(0, 0, 3'b011, 64'h20,   64'h0,                64'h88776655BEEFAB11, 0, 1, "ld_after_sh");
    add(0, 0, 3'b010, 64'h22,   64'h0,                64'h0,                1, 1, "lw_misaligned");
    add(0, 0, 3'b011, 64'h24,   64'h0,                64'h0,                1, 1, "ld_misaligned");
    add(0, 1, 3'b011, 64'h2000, 64'hDEADDEADDEADDEAD, 64'h0,                1, 1, "sd_out_of_range");
    add(0, 0, 3'b011, 64'h0,    64'h0,                64'h0123456789ABCDEF, 0, 1, "ld_0_unchanged");
    add(0, 1, 3'b011, 64'h1FF8, 64'hCAFEF00D12345678, 64'h0,                0, 1, "sd_last_word");
    add(0, 0, 3'b011, 64'h1FF8, 64'h0,                64'hCAFEF00D12345678, 0, 1, "ld_last_word");
    add(0, 0, 3'b111, 64'h20,   64'h0,                64'h0,                1, 1, "funct3_111");
    add(0, 1, 3'b100, 64'h20,   64'h00000000000000FF, 64'h0,                1, 1, "store_f3_100");
    add(0, 0, 3'b011, 64'h20,   64'h0,                64'h88776655BEEFAB11, 0, 1, "ld_20_unchanged");
    // XLEN=32, LATENCY=3
    add(2, 0, 3'b011, 64'h0,    64'h0,                64'h0,                1, 3, "x32_ld_illegal");
    add(2, 1, 3'b010, 64'h4,    64'hDEADBEEF,         64'h0,                0, 3, "x32_sw_4");
    add(2, 0, 3'b010, 64'h4,    64'h0,                64'h00000000DEADBEEF, 0, 3, "x32_lw_4");
    add(2, 0, 3'b000, 64'h7,    64'h0,                64'h00000000FFFFFFDE, 0, 3, "x32_lb_7");
    add(2, 0, 3'b101, 64'h6,    64'h0,                64'h000000000000DEAD, 0, 3, "x32_lhu_6");
    add(2, 0, 3'b110, 64'h4,    64'h0,                64'h0,                1, 3, "x32_lwu_illegal");
    add(2, 1, 3'b010, 64'h1000, 64'h12345678,         64'h0,                1, 3, "x32_sw_out_of_range");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    rd, er, lat, busy);
      checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_busy"}, 64'(busy), 64'(vecs[i].exp_lat + 1));
    end

    // Reset in the middle of BUSY on a LATENCY=4 store aborts it.
    applyStimulus(1, 1'b1, 3'b011, 64'h10, 64'h1111111111111111, rd, er, lat, busy);
    checkOutput("b_sd_seed_err", 64'(er), 64'd0);
    checkOutput("b_sd_seed_lat", 64'(lat), 64'd4);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'h10; req_wdata = 64'h2222222222222222;
    valid_b = 1'b1;
    checkOutput("b_abort_ready", 64'(ready_b), 64'd1);
    @(posedge clk);
    #1 valid_b = 1'b0;
    checkOutput("b_abort_busy", 64'(ready_b), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    #1;
    checkOutput("b_abort_rst_ready",  64'(ready_b),  64'd1);
    checkOutput("b_abort_rst_rvalid", 64'(rvalid_b), 64'd0);
    @(negedge clk);
    reset_b = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (rvalid_b) seen++;
      end
      checkOutput("b_abort_no_resp", 64'(seen), 64'd0);
    end
    applyStimulus(1, 1'b0, 3'b011, 64'h10, 64'h0, rd, er, lat, busy);
    checkOutput("b_ld_after_abort", rd, 64'h1111111111111111);
    checkOutput("b_ld_after_abort_err", 64'(er), 64'd0);

    // Continuous req_valid on the LATENCY=3 instance: one accept per 5 cycles.
    begin
      int accepts, last;
      accepts = 0; last = 0;
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 64'h4; req_wdata = '0;
      valid_c = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (ready_c) begin
          if (accepts > 0) checkOutput("cont_gap", 64'(i - last), 64'd5);
          last = i;
          accepts++;
        end
        @(negedge clk);
      end
      valid_c = 1'b0;
      checkOutput("cont_accepts", 64'(accepts), 64'd4);
      repeat (8) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
